// File: rtl/cpu_defs_pkg.sv
// Shared CPU pipeline definitions: NOP encodings, reset level and the ID->EX payload layout.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package cpu_defs_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ALUOP_W_DEF  = 8;
    localparam int ALUSEL_W_DEF = 3;
    localparam int RADDR_W_DEF  = 5;

    localparam logic [ALUOP_W_DEF-1:0]  EXE_NOP_OP   = 8'h00;
    localparam logic [ALUSEL_W_DEF-1:0] EXE_RES_NOP  = 3'b000;
    localparam logic [RADDR_W_DEF-1:0]  NOPRegAddr   = 5'b00000;
    localparam logic [DATA_W_DEF-1:0]   ZeroWord     = 32'h0000_0000;
    localparam logic                    WriteDisable = 1'b0;
    localparam logic                    RstEnable    = 1'b1;

    // Decoded instruction as it travels from ID into EX.
    typedef struct packed {
        logic [ALUOP_W_DEF-1:0]  aluop;
        logic [ALUSEL_W_DEF-1:0] alusel;
        logic [DATA_W_DEF-1:0]   reg1;
        logic [DATA_W_DEF-1:0]   reg2;
        logic [RADDR_W_DEF-1:0]  wd;
        logic                    wreg;
    } id_ex_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register stage on a flat payload, optional 2-entry skid, synchronous flush.
// Latency: 1 cycle from input transfer to out_vld on an empty stage.
// Backpressure: SKID=1 -> in_rdy = ~skid_vld (registered); SKID=0 -> in_rdy = ~out_vld | out_rdy.
module pipe_skid_buf
    import cpu_defs_pkg::*;
#(
    parameter int W    = 8,
    parameter int SKID = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         flush,
    input  logic         in_vld,
    output logic         in_rdy,
    input  logic [W-1:0] in_dat,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);

    logic         main_vld;
    logic [W-1:0] main_dat;
    logic         skid_vld;
    logic [W-1:0] skid_dat;
    logic         in_xfer;
    logic         out_xfer;

    // The skid variant never looks at out_rdy, so ID sees no combinational path from EX.
    assign in_rdy   = (SKID != 0) ? ~skid_vld : (~main_vld | out_rdy);
    assign in_xfer  = in_vld & in_rdy;
    assign out_xfer = main_vld & out_rdy;
    assign out_vld  = main_vld;
    assign out_dat  = main_dat;

    // Entry update: flush wins, then refill MAIN (oldest first), else park input in SKID.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn == RstEnable) begin
            main_vld <= 1'b0;
            main_dat <= '0;
            skid_vld <= 1'b0;
            skid_dat <= '0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (!main_vld || out_xfer) begin
            if (skid_vld) begin
                main_vld <= 1'b1;
                main_dat <= skid_dat;
            end else begin
                main_vld <= in_xfer;
                if (in_xfer) begin
                    main_dat <= in_dat;
                end
            end
            skid_vld <= 1'b0;
        end else if (in_xfer) begin
            // Only reachable with SKID=1: MAIN is stalled and SKID was free.
            skid_vld <= 1'b1;
            skid_dat <= in_dat;
        end
    end

endmodule

// File: rtl/id_ex_pipe_hs.sv
// ID->EX pipeline register with valid/ready handshake, skid buffer, flush and NOP bubbles.
// Latency: 1 cycle (accept at edge N, visible on ex_* after edge N when empty).
// Backpressure: SKID=1 -> id_ready registered (~skid full); SKID=0 -> id_ready = ~ex_valid | ex_ready.
module id_ex_pipe_hs
    import cpu_defs_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int RADDR_W  = 5,
    parameter int SKID     = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_reg1_i,
    input  logic [DATA_W-1:0]   id_reg2_i,
    input  logic [RADDR_W-1:0]  id_wd_i,
    input  logic                id_wreg,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1_o,
    output logic [DATA_W-1:0]   ex_reg2_o,
    output logic [RADDR_W-1:0]  ex_wd_o,
    output logic                ex_wreg
);

    localparam int W = ALUOP_W + ALUSEL_W + 2 * DATA_W + RADDR_W + 1;

    logic [W-1:0]        in_dat;
    logic [W-1:0]        out_dat;
    logic [ALUOP_W-1:0]  hold_aluop;
    logic [ALUSEL_W-1:0] hold_alusel;
    logic [DATA_W-1:0]   hold_reg1;
    logic [DATA_W-1:0]   hold_reg2;
    logic [RADDR_W-1:0]  hold_wd;
    logic                hold_wreg;

    assign in_dat = {id_aluop, id_alusel, id_reg1_i, id_reg2_i, id_wd_i, id_wreg};
    assign {hold_aluop, hold_alusel, hold_reg1, hold_reg2, hold_wd, hold_wreg} = out_dat;

    pipe_skid_buf #(
        .W    (W),
        .SKID (SKID)
    ) u_buf (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (flush),
        .in_vld  (id_valid),
        .in_rdy  (id_ready),
        .in_dat  (in_dat),
        .out_vld (ex_valid),
        .out_rdy (ex_ready),
        .out_dat (out_dat)
    );

    // Bubble insertion: EX only ever sees NOP fields when nothing valid is held.
    always_comb begin
        ex_aluop  = ALUOP_W'(EXE_NOP_OP);
        ex_alusel = ALUSEL_W'(EXE_RES_NOP);
        ex_reg1_o = DATA_W'(ZeroWord);
        ex_reg2_o = DATA_W'(ZeroWord);
        ex_wd_o   = RADDR_W'(NOPRegAddr);
        ex_wreg   = WriteDisable;
        if (ex_valid) begin
            ex_aluop  = hold_aluop;
            ex_alusel = hold_alusel;
            ex_reg1_o = hold_reg1;
            ex_reg2_o = hold_reg2;
            ex_wd_o   = hold_wd;
            ex_wreg   = hold_wreg;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe_hs.sv
// Directed bench for id_ex_pipe_hs: one skid build and one single-register build.
// Latency: n/a.
// Backpressure: driven by the stimulus.
module tb_id_ex_pipe_hs;
    import cpu_defs_pkg::*;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // SKID=1 instance signals
    logic        flush, id_valid, id_ready, ex_valid, ex_ready;
    logic [7:0]  id_aluop, ex_aluop;
    logic [2:0]  id_alusel, ex_alusel;
    logic [31:0] id_reg1_i, id_reg2_i, ex_reg1_o, ex_reg2_o;
    logic [4:0]  id_wd_i, ex_wd_o;
    logic        id_wreg, ex_wreg;

    // SKID=0 instance signals
    logic        s0_flush, s0_id_valid, s0_id_ready, s0_ex_valid, s0_ex_ready;
    logic [7:0]  s0_id_aluop, s0_ex_aluop;
    logic [2:0]  s0_id_alusel, s0_ex_alusel;
    logic [31:0] s0_id_reg1_i, s0_id_reg2_i, s0_ex_reg1_o, s0_ex_reg2_o;
    logic [4:0]  s0_id_wd_i, s0_ex_wd_o;
    logic        s0_id_wreg, s0_ex_wreg;

    id_ex_pipe_hs #(.SKID(1)) u_dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_aluop(id_aluop), .id_alusel(id_alusel),
        .id_reg1_i(id_reg1_i), .id_reg2_i(id_reg2_i),
        .id_wd_i(id_wd_i), .id_wreg(id_wreg),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_reg1_o(ex_reg1_o), .ex_reg2_o(ex_reg2_o),
        .ex_wd_o(ex_wd_o), .ex_wreg(ex_wreg)
    );

    id_ex_pipe_hs #(.SKID(0)) u_dut_s0 (
        .clk(clk), .resetn(resetn), .flush(s0_flush),
        .id_valid(s0_id_valid), .id_ready(s0_id_ready),
        .id_aluop(s0_id_aluop), .id_alusel(s0_id_alusel),
        .id_reg1_i(s0_id_reg1_i), .id_reg2_i(s0_id_reg2_i),
        .id_wd_i(s0_id_wd_i), .id_wreg(s0_id_wreg),
        .ex_valid(s0_ex_valid), .ex_ready(s0_ex_ready),
        .ex_aluop(s0_ex_aluop), .ex_alusel(s0_ex_alusel),
        .ex_reg1_o(s0_ex_reg1_o), .ex_reg2_o(s0_ex_reg2_o),
        .ex_wd_o(s0_ex_wd_o), .ex_wreg(s0_ex_wreg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input id_ex_payload_t p);
        id_valid  = v;
        id_aluop  = p.aluop;
        id_alusel = p.alusel;
        id_reg1_i = p.reg1;
        id_reg2_i = p.reg2;
        id_wd_i   = p.wd;
        id_wreg   = p.wreg;
    endtask

    task automatic drive_s0(input logic v, input id_ex_payload_t p);
        s0_id_valid  = v;
        s0_id_aluop  = p.aluop;
        s0_id_alusel = p.alusel;
        s0_id_reg1_i = p.reg1;
        s0_id_reg2_i = p.reg2;
        s0_id_wd_i   = p.wd;
        s0_id_wreg   = p.wreg;
    endtask

    function automatic id_ex_payload_t mk(input logic [7:0] op, input logic [31:0] r1, input logic [4:0] wd);
        id_ex_payload_t p;
        p.aluop  = op;
        p.alusel = 3'b001;
        p.reg1   = r1;
        p.reg2   = ~r1;
        p.wd     = wd;
        p.wreg   = 1'b1;
        return p;
    endfunction

    initial begin
        id_ex_payload_t nop;
        nop = '0;
        flush = 1'b0; ex_ready = 1'b0; drive(1'b0, nop);
        s0_flush = 1'b0; s0_ex_ready = 1'b0; drive_s0(1'b0, nop);

        // Reset state
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd1);
        chk("rst_ex_wreg", 32'(ex_wreg), 32'd0);
        step(); step();
        resetn = 1'b0;
        step();
        chk("post_rst_id_ready", 32'(id_ready), 32'd1);

        // Streaming: 8 back-to-back ops, one cycle latency, no stalls
        ex_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, mk(8'h21, 32'(i), 5'(i)));
            chk("stream_id_ready", 32'(id_ready), 32'd1);
            step();
            chk("stream_ex_valid", 32'(ex_valid), 32'd1);
            chk("stream_ex_aluop", 32'(ex_aluop), 32'h21);
            chk("stream_ex_reg1", ex_reg1_o, 32'(i));
            chk("stream_ex_wd", 32'(ex_wd_o), 32'(i));
        end
        drive(1'b0, nop);
        step();
        chk("stream_drain", 32'(ex_valid), 32'd0);

        // Backpressure: A in MAIN, B in SKID, C held off
        ex_ready = 1'b0;
        drive(1'b1, mk(8'h0A, 32'hA0, 5'd10));
        step();
        chk("bp_A_ex", ex_reg1_o, 32'hA0);
        chk("bp_rdy_after_A", 32'(id_ready), 32'd1);
        drive(1'b1, mk(8'h0B, 32'hB0, 5'd11));
        step();
        chk("bp_still_A", ex_reg1_o, 32'hA0);
        chk("bp_rdy_after_B", 32'(id_ready), 32'd0);
        drive(1'b1, mk(8'h0C, 32'hC0, 5'd12));
        step();
        chk("bp_full_A", ex_reg1_o, 32'hA0);
        chk("bp_full_rdy", 32'(id_ready), 32'd0);
        ex_ready = 1'b1;
        step();
        chk("bp_out_B", ex_reg1_o, 32'hB0);
        chk("bp_out_B_wd", 32'(ex_wd_o), 32'd11);
        chk("bp_rdy_reopen", 32'(id_ready), 32'd1);
        step();
        chk("bp_out_C", ex_reg1_o, 32'hC0);
        chk("bp_out_C_reg2", ex_reg2_o, ~32'hC0);
        drive(1'b0, nop);
        step();
        chk("bp_empty", 32'(ex_valid), 32'd0);

        // Flush with both entries full and D presented
        ex_ready = 1'b0;
        drive(1'b1, mk(8'h0E, 32'hE0, 5'd14));
        step();
        drive(1'b1, mk(8'h0F, 32'hF0, 5'd15));
        step();
        chk("fl_full", 32'(id_ready), 32'd0);
        drive(1'b1, mk(8'h0D, 32'hD0, 5'd13));
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, nop);
        chk("fl_ex_valid", 32'(ex_valid), 32'd0);
        chk("fl_ex_wreg", 32'(ex_wreg), 32'd0);
        chk("fl_ex_aluop", 32'(ex_aluop), 32'd0);
        chk("fl_id_ready", 32'(id_ready), 32'd1);
        ex_ready = 1'b1;
        step();
        chk("fl_D_dropped", 32'(ex_valid), 32'd0);

        // Bubbles: idle input, EX sees NOP fields
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bub_aluop", 32'(ex_aluop), 32'd0);
            chk("bub_wd", 32'(ex_wd_o), 32'd0);
            chk("bub_wreg", 32'(ex_wreg), 32'd0);
            chk("bub_reg1", ex_reg1_o, 32'd0);
        end

        // Async reset mid-cycle with both entries full
        ex_ready = 1'b0;
        drive(1'b1, mk(8'h55, 32'h55, 5'd5));
        step();
        drive(1'b1, mk(8'h66, 32'h66, 5'd6));
        step();
        drive(1'b0, nop);
        chk("ar_full", 32'(id_ready), 32'd0);
        #2;
        resetn = 1'b1;
        #1;
        chk("ar_ex_valid", 32'(ex_valid), 32'd0);
        chk("ar_ex_aluop", 32'(ex_aluop), 32'd0);
        chk("ar_ex_reg1", ex_reg1_o, 32'd0);
        chk("ar_ex_wreg", 32'(ex_wreg), 32'd0);
        chk("ar_id_ready", 32'(id_ready), 32'd1);
        step();
        resetn = 1'b0;
        step();
        chk("ar_stays_empty", 32'(ex_valid), 32'd0);

        // SKID=0 build: streaming
        s0_ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_s0(1'b1, mk(8'h21, 32'(i + 16), 5'(i)));
            step();
            chk("s0_stream_reg1", s0_ex_reg1_o, 32'(i + 16));
            chk("s0_stream_rdy", 32'(s0_id_ready), 32'd1);
        end
        drive_s0(1'b0, nop);
        step();
        chk("s0_drain", 32'(s0_ex_valid), 32'd0);

        // SKID=0 build: backpressure, id_ready follows ex_ready combinationally
        s0_ex_ready = 1'b0;
        drive_s0(1'b1, mk(8'h0A, 32'hA1, 5'd1));
        step();
        chk("s0_A_ex", s0_ex_reg1_o, 32'hA1);
        chk("s0_full_rdy", 32'(s0_id_ready), 32'd0);
        drive_s0(1'b1, mk(8'h0B, 32'hB1, 5'd2));
        step();
        chk("s0_still_A", s0_ex_reg1_o, 32'hA1);
        s0_ex_ready = 1'b1;
        #1;
        chk("s0_comb_rdy", 32'(s0_id_ready), 32'd1);
        step();
        chk("s0_out_B", s0_ex_reg1_o, 32'hB1);
        drive_s0(1'b0, nop);
        step();
        chk("s0_empty", 32'(s0_ex_valid), 32'd0);
        chk("s0_bub_wreg", 32'(s0_ex_wreg), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
